aux_run_controller: RTL

//   Run-control sequencer that produces the CPU-wide clock enable.

---
 rtl/aux_pkg.sv | 14 +
 rtl/aux_run_controller_if.sv | 29 ++
 rtl/aux_btn_pulse.sv | 26 ++
 rtl/aux_run_controller.sv | 113 +++++++++++
 4 files changed

// File: rtl/aux_pkg.sv
// Shared constants for the run-control sequencer: FSM state codes and halt-cause codes.
package aux_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_BURST  = 2'd3;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_HALT  = 2'd1;
  localparam logic [1:0] CAUSE_BREAK = 2'd2;
  localparam logic [1:0] CAUSE_DONE  = 2'd3;

endpackage

// File: rtl/aux_run_controller_if.sv
// Run-control bundle between the board/datapath (master) and the sequencer (slave).
interface aux_run_controller_if #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned BURST_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 32
);
  logic                   resume;
  logic                   step;
  logic                   halt;
  logic                   burst_start;
  logic [BURST_WIDTH-1:0] burst_len;
  logic                   bp_en;
  logic [PC_WIDTH-1:0]    bp_addr;
  logic [PC_WIDTH-1:0]    pc;
  logic                   en;
  logic                   halted;
  logic [1:0]             cause;
  logic [CNT_WIDTH-1:0]   cycles;

  modport master (
    output resume, step, halt, burst_start, burst_len, bp_en, bp_addr, pc,
    input  en, halted, cause, cycles
  );

  modport slave (
    input  resume, step, halt, burst_start, burst_len, bp_en, bp_addr, pc,
    output en, halted, cause, cycles
  );
endinterface

// File: rtl/aux_btn_pulse.sv
// Synchronizes an asynchronous button level and emits a one-cycle pulse on its rising edge.
module aux_btn_pulse #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/aux_run_controller.sv
// Run-control sequencer generating the CPU-wide clock enable (run, halt, breakpoint,
// single-step and N-cycle burst).
module aux_run_controller
  import aux_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned BURST_WIDTH = 16,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                rst,
  aux_run_controller_if.slave bus
);

  logic                   resume_pulse;
  logic                   step_pulse;
  logic [1:0]             state_q, state_d;
  logic [1:0]             cause_q, cause_d;
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  logic                   skip_q, skip_d;
  logic [CNT_WIDTH-1:0]   cycles_q;
  logic                   en_q;
  logic                   bp_hit;
  logic                   en;

  aux_btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_resume_pulse (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.resume),
    .pulse (resume_pulse)
  );

  aux_btn_pulse #(.SYNC_STAGES(SYNC_STAGES)) u_step_pulse (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.step),
    .pulse (step_pulse)
  );

  // Breakpoint is combinational so the matching instruction never gets enabled.
  assign en_q   = (state_q != ST_HALTED);
  assign bp_hit = bus.bp_en & (bus.pc == bus.bp_addr) & ~skip_q & en_q;
  assign en     = en_q & ~bp_hit;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    if (en) skip_d = 1'b0;
    case (state_q)
      ST_HALTED: begin
        // Every exit arms the skip flag so a breakpoint PC executes once on resume.
        if (resume_pulse) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (step_pulse) begin
          state_d = ST_STEP;
          skip_d  = 1'b1;
        end else if (bus.burst_start && (bus.burst_len != '0)) begin
          state_d = ST_BURST;
          cnt_d   = bus.burst_len;
          skip_d  = 1'b1;
        end
      end
      default: begin
        if (bp_hit) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BREAK;
          cnt_d   = '0;
        end else if (bus.halt) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HALT;
          cnt_d   = '0;
        end else if (state_q == ST_STEP) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_DONE;
        end else if (state_q == ST_BURST) begin
          if (cnt_q == BURST_WIDTH'(1)) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - BURST_WIDTH'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cause_q  <= CAUSE_NONE;
      cnt_q    <= '0;
      skip_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
      skip_q   <= skip_d;
      cycles_q <= cycles_q + CNT_WIDTH'(en);
    end
  end

  assign bus.en     = en;
  assign bus.halted = (state_q == ST_HALTED);
  assign bus.cause  = cause_q;
  assign bus.cycles = cycles_q;

endmodule
